// File: rtl/int_to_fpu.sv
// int_to_fpu: iterative 32-bit signed integer to FPU float converter.
// Float format: sign[31], exponent[30:24] (bias 63), fraction[23:0] with
// an implicit leading one. One start/done transaction at a time; the
// normalizer shifts the magnitude left by one bit per cycle.
// Optional feature macro: INT_TO_FPU_RNE_EN selects round-to-nearest-even;
// when it is undefined the result is truncated (round toward zero).
module int_to_fpu (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] int_in,
    output logic [31:0] data_out,
    output logic [3:0]  status_out,
    output logic        busy,
    output logic        done
);

    localparam logic [3:0] ST_EXACT   = 4'b0001;
    localparam logic [3:0] ST_INEXACT = 4'b0010;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ABS,
        S_NORM,
        S_ROUND,
        S_PACK
    } state_t;

    typedef struct packed {
        logic [6:0]  exp;
        logic [23:0] frac;
        logic        inexact;
    } round_t;

    state_t state_q, state_d;

    // Working datapath registers (not reset: only meaningful while busy)
    logic signed [31:0] op_q, op_d;
    logic               sign_q, sign_d;
    logic [31:0]        mag_q, mag_d;
    logic [4:0]         shift_q, shift_d;
    logic [6:0]         exp_q, exp_d;
    logic [23:0]        frac_q, frac_d;
    logic [3:0]         stat_q, stat_d;

    // Visible outputs (reset)
    logic [31:0]        data_out_q, data_out_d;
    logic [3:0]         status_out_q, status_out_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [31:0]        abs_mag;
    round_t             rnd;

    // Exponent and fraction from a normalized magnitude (bit 31 set, so
    // only bits 30:0 carry information). Exponent fits 7 bits: max 95.
    function automatic round_t round_norm(input logic [30:0] m,
                                          input logic [4:0]  sh);
        round_t res;
        logic   g, r, s;
        res.exp     = 7'd94 - {2'd0, sh};
        res.frac    = m[30:7];
        g           = m[6];
        r           = m[5];
        s           = |m[4:0];
        res.inexact = g | r | s;
`ifdef INT_TO_FPU_RNE_EN
        if (g && (r || s || m[7])) begin
            if (&m[30:7]) begin
                res.frac = '0;
                res.exp  = res.exp + 7'd1;
            end else begin
                res.frac = m[30:7] + 24'd1;
            end
        end
`endif
        return res;
    endfunction

    // Magnitude of the captured operand; 0x80000000 maps to itself
    assign abs_mag = op_q[31] ? $unsigned(-op_q) : $unsigned(op_q);
    assign rnd     = round_norm(mag_q[30:0], shift_q);

    // State register
    always_ff @(posedge clock) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_ABS;
            S_ABS:   state_d = (abs_mag == 32'd0) ? S_PACK : S_NORM;
            S_NORM:  if (mag_q[31]) state_d = S_ROUND;
            S_ROUND: state_d = S_PACK;
            S_PACK:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath next values: capture, absolute value, shift, round
    always_comb begin
        op_d    = op_q;
        sign_d  = sign_q;
        mag_d   = mag_q;
        shift_d = shift_q;
        exp_d   = exp_q;
        frac_d  = frac_q;
        stat_d  = stat_q;
        case (state_q)
            S_IDLE: begin
                if (start) op_d = int_in;
            end
            S_ABS: begin
                sign_d  = op_q[31];
                mag_d   = abs_mag;
                shift_d = 5'd0;
                if (abs_mag == 32'd0) begin
                    sign_d = 1'b0;
                    exp_d  = 7'd0;
                    frac_d = 24'd0;
                    stat_d = ST_EXACT;
                end
            end
            S_NORM: begin
                if (!mag_q[31]) begin
                    mag_d   = {mag_q[30:0], 1'b0};
                    shift_d = shift_q + 5'd1;
                end
            end
            S_ROUND: begin
                exp_d  = rnd.exp;
                frac_d = rnd.frac;
                stat_d = rnd.inexact ? ST_INEXACT : ST_EXACT;
            end
            default: ;
        endcase
    end

    // Output logic: busy/done handshake and result publication
    always_comb begin
        data_out_d   = data_out_q;
        status_out_d = status_out_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) busy_d = 1'b1;
            end
            S_PACK: begin
                data_out_d   = {sign_q, exp_q, frac_q};
                status_out_d = stat_q;
                busy_d       = 1'b0;
                done_d       = 1'b1;
            end
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clock) begin
        op_q    <= op_d;
        sign_q  <= sign_d;
        mag_q   <= mag_d;
        shift_q <= shift_d;
        exp_q   <= exp_d;
        frac_q  <= frac_d;
        stat_q  <= stat_d;
    end

    // Output registers; reset clears everything and drops any operation
    always_ff @(posedge clock) begin
        if (reset) begin
            data_out_q   <= 32'd0;
            status_out_q <= 4'd0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            data_out_q   <= data_out_d;
            status_out_q <= status_out_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign data_out   = data_out_q;
    assign status_out = status_out_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_int_to_fpu.sv
// Self-checking bench for int_to_fpu with a high-level arithmetic model.
module tb_int_to_fpu;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] int_in;
    logic [31:0] data_out;
    logic [3:0]  status_out;
    logic        busy;
    logic        done;

    int n_tests = 0;
    int n_fail  = 0;

    int_to_fpu dut (
        .clock      (clk),
        .reset      (reset),
        .start      (start),
        .int_in     (int_in),
        .data_out   (data_out),
        .status_out (status_out),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got,
                            input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: value-level conversion, {status, data}
    function automatic logic [35:0] ref_conv(input logic [31:0] v);
        logic [63:0] mag, mant, rem, half;
        logic        sgn, inexact;
        int          p, k, e;
        if (v == 32'd0) return {4'b0001, 32'h0};
        sgn  = v[31];
        mag  = sgn ? (64'h1_0000_0000 - {32'd0, v}) : {32'd0, v};
        p    = 31;
        while (mag[p] == 1'b0) p--;
        inexact = 1'b0;
        if (p >= 24) begin
            k       = p - 24;
            mant    = mag >> k;
            rem     = mag & ((64'd1 << k) - 64'd1);
            inexact = (rem != 64'd0);
`ifdef INT_TO_FPU_RNE_EN
            if (k > 0) begin
                half = 64'd1 << (k - 1);
                if (rem > half || (rem == half && mant[0])) mant = mant + 64'd1;
            end
`else
            half = 64'd0;
`endif
        end else begin
            mant = mag << (24 - p);
        end
        e = 63 + p;
        if (mant == (64'd1 << 25)) begin
            mant = 64'd1 << 24;
            e++;
        end
        return {(inexact ? 4'b0010 : 4'b0001), sgn, 7'(e), mant[23:0]};
    endfunction

    function automatic int ref_latency(input logic [31:0] v);
        logic [31:0] mag;
        int          lz;
        if (v == 32'd0) return 2;
        mag = v[31] ? (~v + 32'd1) : v;
        lz  = 0;
        while (mag[31 - lz] == 1'b0) lz++;
        return lz + 4;
    endfunction

    task automatic wait_done(input int limit, output int edges);
        edges = 0;
        while (!done && edges < limit) begin
            @(posedge clk); #1;
            edges++;
        end
    endtask

    // One full conversion from IDLE; returns result, edges after accept
    task automatic conv(input logic [31:0] v, output logic [31:0] d,
                        output logic [3:0] st, output int edges,
                        output logic busy_ok);
        start  = 1'b1;
        int_in = v;
        @(posedge clk); #1;
        start   = 1'b0;
        int_in  = $urandom;
        edges   = 0;
        busy_ok = 1'b1;
        while (!done && edges < 200) begin
            if (!busy) busy_ok = 1'b0;
            @(posedge clk); #1;
            edges++;
        end
        d  = data_out;
        st = status_out;
    endtask

    task automatic run_check(input string tag, input logic [31:0] v,
                             input logic [31:0] exp_d, input logic [3:0] exp_st);
        logic [31:0] d;
        logic [3:0]  st;
        int          edges;
        logic        bok;
        conv(v, d, st, edges, bok);
        check_eq({tag, "_data"}, {32'd0, d}, {32'd0, exp_d});
        check_eq({tag, "_status"}, {60'd0, st}, {60'd0, exp_st});
        check_eq({tag, "_latency"}, 64'(edges), 64'(ref_latency(v)));
        check_eq({tag, "_busy"}, {63'd0, bok}, 64'd1);
        @(posedge clk); #1;
        check_eq({tag, "_done_pulse"}, {63'd0, done}, 64'd0);
        check_eq({tag, "_hold"}, {32'd0, data_out}, {32'd0, exp_d});
    endtask

    initial begin
        logic [35:0] r;
        logic [31:0] v;
        int          edges, e2, cnt;

        reset  = 1'b1;
        start  = 1'b0;
        int_in = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_data", {32'd0, data_out}, 64'd0);
        check_eq("rst_status", {60'd0, status_out}, 64'd0);
        check_eq("rst_busy", {63'd0, busy}, 64'd0);
        check_eq("rst_done", {63'd0, done}, 64'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Directed values with fixed expectations
        run_check("one", 32'h0000_0001, 32'h3F00_0000, 4'b0001);
        run_check("neg2", 32'hFFFF_FFFE, 32'hC000_0000, 4'b0001);
        run_check("zero", 32'h0000_0000, 32'h0000_0000, 4'b0001);
        run_check("minint", 32'h8000_0000, 32'hDE00_0000, 4'b0001);
`ifdef INT_TO_FPU_RNE_EN
        run_check("maxint", 32'h7FFF_FFFF, 32'h5E00_0000, 4'b0010);
        run_check("tie_even", 32'h0200_0001, 32'h5800_0000, 4'b0010);
        run_check("tie_up", 32'h0200_0003, 32'h5800_0002, 4'b0010);
`else
        run_check("maxint", 32'h7FFF_FFFF, 32'h5DFF_FFFF, 4'b0010);
        run_check("trunc", 32'h0200_0003, 32'h5800_0001, 4'b0010);
`endif
        run_check("neg1", 32'hFFFF_FFFF, 32'hBF00_0000, 4'b0001);

        // Randomized values of varied magnitude against the model
        for (int i = 0; i < 40; i++) begin
            v = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 1) == 1) v = ~v + 32'd1;
            r = ref_conv(v);
            run_check("rand", v, r[31:0], r[35:32]);
        end

        // start pulse during NORMALIZE must be ignored
        start  = 1'b1;
        int_in = 32'd1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        start  = 1'b1;
        int_in = 32'h1234_5678;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(200, edges);
        check_eq("ign_latency", 64'(edges + 7), 64'd35);
        check_eq("ign_data", {32'd0, data_out}, 64'h3F00_0000);
        cnt = 0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk); #1;
            if (done) cnt++;
        end
        check_eq("ign_no_extra_done", 64'(cnt), 64'd0);

        // Reset mid-NORMALIZE clears outputs and suppresses done
        start  = 1'b1;
        int_in = 32'd1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        check_eq("mid_rst_data", {32'd0, data_out}, 64'd0);
        check_eq("mid_rst_status", {60'd0, status_out}, 64'd0);
        check_eq("mid_rst_busy", {63'd0, busy}, 64'd0);
        check_eq("mid_rst_done", {63'd0, done}, 64'd0);
        reset = 1'b0;
        cnt = 0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            if (done) cnt++;
        end
        check_eq("mid_rst_no_done", 64'(cnt), 64'd0);

        // start held high through done restarts on the following edge
        start  = 1'b1;
        int_in = 32'd0;
        @(posedge clk); #1;
        wait_done(20, edges);
        check_eq("b2b_first", 64'(edges), 64'd2);
        @(posedge clk); #1;
        check_eq("b2b_busy", {63'd0, busy}, 64'd1);
        wait_done(20, e2);
        start = 1'b0;
        check_eq("b2b_gap", 64'(e2 + 1), 64'd3);
        repeat (5) @(posedge clk);
        #1;
        check_eq("b2b_idle", {63'd0, busy}, 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
